apb_slave_regfile: RTL



---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_regfile_mem.sv | 44 ++++
 rtl/apb_slave_regfile.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state type, PSLVERR encodings and default bus widths
// used by both the requester and the completer.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;

endpackage

// File: rtl/apb_regfile_mem.sv
// Word-addressed register storage: combinational read, synchronous write,
// whole array cleared asynchronously by PRESETn.
module apb_regfile_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] words [DEPTH];
  logic                  rd_in_range;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_WIDTH-1:0] word_reg;

      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          word_reg <= '0;
        end else if (wr_en && (wr_addr == ADDR_WIDTH'(gi))) begin
          word_reg <= wr_data;
        end
      end

      assign words[gi] = word_reg;
    end
  endgenerate

  // Out-of-range reads return 0 so the index never leaves the array.
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
  assign rd_data     = rd_in_range ? words[rd_addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer over a register file with programmable wait states and an
// error response for addresses beyond DEPTH; all bus outputs are registered.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int DEPTH      = 64,
  parameter int WAIT_W     = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [WAIT_W-1:0]     wait_cfg,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  apb_state_e state_reg, state_next;

  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  write_reg, write_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  err_reg, err_next;
  logic [WAIT_W-1:0]     cnt_reg, cnt_next;
  logic                  pready_reg, pready_next;
  logic                  pslverr_reg, pslverr_next;
  logic [DATA_WIDTH-1:0] prdata_reg, prdata_next;

  logic                  setup;
  logic                  addr_err;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign setup    = (state_reg == IDLE) && PSEL && !PENABLE;
  assign addr_err = {1'b0, PADDR} >= DEPTH_W;

  // Zero-wait reads are served from the live address at the setup edge;
  // every later read uses the latched copy.
  assign mem_rd_addr = (state_reg == IDLE) ? PADDR : addr_reg;

  apb_regfile_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .wr_en   (mem_we),
    .wr_addr (addr_reg),
    .wr_data (wdata_reg),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (PSEL && !PENABLE) state_next = ACCESS;
      ACCESS:  if (!PSEL || pready_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_next    = addr_reg;
    write_next   = write_reg;
    wdata_next   = wdata_reg;
    err_next     = err_reg;
    cnt_next     = cnt_reg;
    pready_next  = 1'b0;
    pslverr_next = APB_OKAY;
    prdata_next  = '0;
    mem_we       = 1'b0;

    if (setup) begin
      addr_next  = PADDR;
      write_next = PWRITE;
      wdata_next = PWDATA;
      err_next   = addr_err;
      cnt_next   = wait_cfg;
      if (wait_cfg == '0) begin
        pready_next  = 1'b1;
        pslverr_next = addr_err ? APB_ERR : APB_OKAY;
        if (!PWRITE && !addr_err) prdata_next = mem_rdata;
      end
    end else if ((state_reg == ACCESS) && PSEL && !pready_reg) begin
      cnt_next = cnt_reg - 1'b1;
      if (cnt_reg == WAIT_W'(1)) begin
        pready_next  = 1'b1;
        pslverr_next = err_reg ? APB_ERR : APB_OKAY;
        if (!write_reg && !err_reg) prdata_next = mem_rdata;
      end
    end else if ((state_reg == ACCESS) && PSEL && pready_reg) begin
      // Completion edge: the write lands here so a back-to-back read sees it.
      mem_we = write_reg && !err_reg;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      err_reg     <= 1'b0;
      cnt_reg     <= '0;
      pready_reg  <= 1'b0;
      pslverr_reg <= APB_OKAY;
      prdata_reg  <= '0;
    end else begin
      addr_reg    <= addr_next;
      write_reg   <= write_next;
      wdata_reg   <= wdata_next;
      err_reg     <= err_next;
      cnt_reg     <= cnt_next;
      pready_reg  <= pready_next;
      pslverr_reg <= pslverr_next;
      prdata_reg  <= prdata_next;
    end
  end

  assign PREADY  = pready_reg;
  assign PSLVERR = pslverr_reg;
  assign PRDATA  = prdata_reg;

endmodule
